point_fb_writer: RTL and testbench

//   Consumer end of the rasterizer point stream: accepts {y,x} pixel points (write strobe + point
//   + done level), buffers them in a FIFO, and writes one colour word per point into framebuffer

---
 rtl/point_fb_writer_if.sv | 32 +++
 rtl/point_fb_writer.sv | 162 ++++++++++++++++
 tb/tb_point_fb_writer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/point_fb_writer_if.sv
// Point-stream / framebuffer-port bundle for point_fb_writer.
// The master side drives points and memory ready; the slave side is the writer.
interface point_fb_writer_if #(
  parameter int COLOR_W = 16,
  parameter int ADDR_W  = 19
);
  logic               i_write;
  logic [31:0]        i_point;
  logic               i_done;
  logic [COLOR_W-1:0] i_color;
  logic               i_clear;
  logic               o_mem_we;
  logic [ADDR_W-1:0]  o_mem_addr;
  logic [COLOR_W-1:0] o_mem_data;
  logic               i_mem_ready;
  logic               o_flushed;
  logic               o_overflow;
  logic [31:0]        o_pix_count;
  logic [15:0]        o_drop_count;

  modport master (
    output i_write, i_point, i_done, i_color, i_clear, i_mem_ready,
    input  o_mem_we, o_mem_addr, o_mem_data, o_flushed, o_overflow,
           o_pix_count, o_drop_count
  );

  modport slave (
    input  i_write, i_point, i_done, i_color, i_clear, i_mem_ready,
    output o_mem_we, o_mem_addr, o_mem_data, o_flushed, o_overflow,
           o_pix_count, o_drop_count
  );
endinterface

// File: rtl/point_fb_writer.sv
// Buffers {y,x} points with their colour and writes one colour word per
// in-bounds point to framebuffer memory over a we/ready handshake.
module point_fb_writer #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int COLOR_W       = 16,
  parameter int ADDR_W        = 19,
  parameter int FIFO_DEPTH    = 8
) (
  input logic              i_clk,
  input logic              i_rst_n,
  point_fb_writer_if.slave bus
);

  localparam int IDX_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = 32 + COLOR_W;
  localparam logic [16:0] WIDTH_LIM  = 17'(SCREEN_WIDTH);
  localparam logic [16:0] HEIGHT_LIM = 17'(SCREEN_HEIGHT);
  localparam logic [31:0] ROW_STRIDE = 32'(SCREEN_WIDTH);
  localparam logic [IDX_W:0] PTR_ONE = (IDX_W+1)'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t             state;
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [IDX_W:0]     wr_ptr;
  logic [IDX_W:0]     rd_ptr;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic               empty;
  logic               full;
  logic               pop;
  logic               push;
  logic               head_ok;
  logic [15:0]        head_x;
  logic [15:0]        head_y;
  logic [COLOR_W-1:0] head_color;

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [COLOR_W-1:0] mem_data;
  logic               overflow;
  logic [31:0]        pix_count;
  logic [15:0]        drop_count;

  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] lin;
    lin = {16'd0, y} * ROW_STRIDE + {16'd0, x};
    return ADDR_W'(lin);
  endfunction

  function automatic logic in_bounds(input logic [15:0] x, input logic [15:0] y);
    return ({1'b0, x} < WIDTH_LIM) && ({1'b0, y} < HEIGHT_LIM);
  endfunction

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign wr_idx  = wr_ptr[IDX_W-1:0];
  assign rd_idx  = rd_ptr[IDX_W-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_idx == rd_idx) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
  assign {head_y, head_x, head_color} = fifo_mem[rd_idx];
  assign head_ok = in_bounds(head_x, head_y);

  // Pop decision: IDLE pops any head (load or drop); WRITE only chains an in-bounds head.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = !empty;
      WRITE:   pop = bus.i_mem_ready && !empty && head_ok;
      default: pop = 1'b0;
    endcase
  end

  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push = bus.i_write && (!full || pop);

  // Point storage; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_idx] <= {bus.i_point, bus.i_color};
    end
  end

  // FIFO pointers and write-port FSM.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      state    <= IDLE;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case (state)
        IDLE: begin
          if (!empty && head_ok) begin
            mem_addr <= pixel_addr(head_x, head_y);
            mem_data <= head_color;
            mem_we   <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (bus.i_mem_ready) begin
            if (!empty && head_ok) begin
              mem_addr <= pixel_addr(head_x, head_y);
              mem_data <= head_color;
            end else begin
              mem_we <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: begin
          mem_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Status counters; a clear beats any increment on the same edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      overflow   <= 1'b0;
      pix_count  <= 32'd0;
      drop_count <= 16'd0;
    end else if (bus.i_clear) begin
      overflow   <= 1'b0;
      pix_count  <= 32'd0;
      drop_count <= 16'd0;
    end else begin
      if (state == WRITE && bus.i_mem_ready) begin
        pix_count <= pix_count + 32'd1;
      end
      if (state == IDLE && !empty && !head_ok && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
      if (bus.i_write && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign bus.o_mem_we     = mem_we;
  assign bus.o_mem_addr   = mem_addr;
  assign bus.o_mem_data   = mem_data;
  assign bus.o_overflow   = overflow;
  assign bus.o_pix_count  = pix_count;
  assign bus.o_drop_count = drop_count;
  assign bus.o_flushed    = bus.i_done && empty && (state == IDLE);

endmodule

// File: tb/tb_point_fb_writer.sv
// Directed and randomized bench for point_fb_writer against a queue-based
// model of which points reach memory and which are dropped.
module tb_point_fb_writer;
  localparam int W = 640;
  localparam int H = 480;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  point_fb_writer_if #(.COLOR_W(16), .ADDR_W(19)) bus ();

  point_fb_writer #(
    .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .COLOR_W(16), .ADDR_W(19), .FIFO_DEPTH(8)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_pix = 0;
  int exp_drops = 0;

  logic [18:0] got_addr[$];
  logic [15:0] got_data[$];
  int          got_cyc[$];
  logic [18:0] exp_addr[$];
  logic [15:0] exp_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change just after the rising edge, so the falling edge sees what the next edge sees.
  always @(negedge clk) begin
    if (rst_n && bus.o_mem_we && bus.i_mem_ready) begin
      got_addr.push_back(bus.o_mem_addr);
      got_data.push_back(bus.o_mem_data);
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Reference: a pixel is written iff it lies on screen, at row-major address.
  task automatic expect_point(input int x, input int y, input logic [15:0] c);
    if (x < W && y < H) begin
      exp_addr.push_back(19'(y * W + x));
      exp_data.push_back(c);
      exp_pix++;
    end else begin
      exp_drops++;
    end
  endtask

  task automatic push_point(input int x, input int y, input logic [15:0] c);
    bus.i_write = 1'b1;
    bus.i_point = {16'(y), 16'(x)};
    bus.i_color = c;
    tick();
    bus.i_write = 1'b0;
  endtask

  task automatic rand_point(output int x, output int y);
    int sel;
    sel = int'($urandom_range(0, 9));
    x = int'($urandom_range(0, W - 1));
    y = int'($urandom_range(0, H - 1));
    if (sel == 0) x = int'($urandom_range(W, 65535));
    else if (sel == 1) y = int'($urandom_range(H, 65535));
    else if (sel == 2) begin x = W - 1; y = H - 1; end
    else if (sel == 3) begin x = 0; y = 0; end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    exp_addr.delete(); exp_data.delete();
    exp_pix = 0;
    exp_drops = 0;
  endtask

  task automatic wait_flushed(input string tag, input int budget, input bit rand_ready);
    int k = 0;
    while (!bus.o_flushed && k < budget) begin
      if (rand_ready) bus.i_mem_ready = ($urandom_range(0, 3) != 0);
      tick();
      k++;
    end
    check(tag, 64'(bus.o_flushed), 64'd1);
    bus.i_mem_ready = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    while (exp_addr.size() > 0) begin
      if (got_addr.size() == 0) begin
        check({tag, " missing write"}, 64'(exp_addr.size()), 64'd0);
        exp_addr.delete(); exp_data.delete();
      end else begin
        check({tag, " addr"}, 64'(got_addr.pop_front()), 64'(exp_addr.pop_front()));
        check({tag, " data"}, 64'(got_data.pop_front()), 64'(exp_data.pop_front()));
        void'(got_cyc.pop_front());
      end
    end
    check({tag, " extra writes"}, 64'(got_addr.size()), 64'd0);
    got_addr.delete(); got_data.delete(); got_cyc.delete();
  endtask

  initial begin
    int x, y, n;
    logic [15:0] c;
    logic [18:0] stall_addr;
    logic [15:0] stall_data;

    bus.i_write = 1'b0; bus.i_point = 32'd0; bus.i_done = 1'b1;
    bus.i_color = 16'd0; bus.i_clear = 1'b0; bus.i_mem_ready = 1'b0;
    apply_reset();

    check("reset mem_we", 64'(bus.o_mem_we), 64'd0);
    check("reset addr", 64'(bus.o_mem_addr), 64'd0);
    check("reset data", 64'(bus.o_mem_data), 64'd0);
    check("reset overflow", 64'(bus.o_overflow), 64'd0);
    check("reset pix", 64'(bus.o_pix_count), 64'd0);
    check("reset drop", 64'(bus.o_drop_count), 64'd0);
    check("reset flushed", 64'(bus.o_flushed), 64'd1);

    // Single point, two-edge latency to the write request.
    bus.i_mem_ready = 1'b1;
    expect_point(3, 2, 16'hF800);
    push_point(3, 2, 16'hF800);
    check("t1 we after push", 64'(bus.o_mem_we), 64'd0);
    check("t1 flushed buffered", 64'(bus.o_flushed), 64'd0);
    tick();
    check("t1 we after load", 64'(bus.o_mem_we), 64'd1);
    check("t1 addr", 64'(bus.o_mem_addr), 64'd1283);
    check("t1 data", 64'(bus.o_mem_data), 64'hF800);
    tick();
    check("t1 we released", 64'(bus.o_mem_we), 64'd0);
    check("t1 pix", 64'(bus.o_pix_count), 64'd1);
    check("t1 flushed", 64'(bus.o_flushed), 64'd1);
    bus.i_mem_ready = 1'b0;
    drain_check("t1");

    // Eight points against a stalled memory, then a back-to-back drain.
    apply_reset();
    bus.i_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      x = int'($urandom_range(0, W - 1)); y = int'($urandom_range(0, H - 1));
      c = 16'($urandom);
      expect_point(x, y, c);
      push_point(x, y, c);
    end
    stall_addr = exp_addr[0];
    stall_data = exp_data[0];
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t2 stall we", 64'(bus.o_mem_we), 64'd1);
      check("t2 stall addr", 64'(bus.o_mem_addr), 64'(stall_addr));
      check("t2 stall data", 64'(bus.o_mem_data), 64'(stall_data));
    end
    check("t2 overflow", 64'(bus.o_overflow), 64'd0);
    bus.i_done = 1'b1;
    bus.i_mem_ready = 1'b1;
    wait_flushed("t2 flushed", 40, 1'b0);
    check("t2 write count", 64'(got_cyc.size()), 64'd8);
    for (int i = 1; i < got_cyc.size(); i++) begin
      check("t2 consecutive", 64'(got_cyc[i] - got_cyc[0]), 64'(i));
    end
    check("t2 pix", 64'(bus.o_pix_count), 64'(exp_pix));
    drain_check("t2");

    // Ten points into one in-flight slot plus eight buffered: the tenth is lost.
    apply_reset();
    bus.i_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      x = int'($urandom_range(0, W - 1)); y = int'($urandom_range(0, H - 1));
      c = 16'($urandom);
      if (i < 9) expect_point(x, y, c);
      push_point(x, y, c);
    end
    check("t3 overflow", 64'(bus.o_overflow), 64'd1);
    bus.i_done = 1'b1;
    bus.i_mem_ready = 1'b1;
    wait_flushed("t3 flushed", 40, 1'b0);
    check("t3 pix", 64'(bus.o_pix_count), 64'd9);
    drain_check("t3");
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    exp_pix = 0;
    check("t3 clear overflow", 64'(bus.o_overflow), 64'd0);
    check("t3 clear pix", 64'(bus.o_pix_count), 64'd0);

    // Bounds: one past each edge is dropped, the far corner is written.
    bus.i_mem_ready = 1'b1;
    expect_point(640, 0, 16'h1111); push_point(640, 0, 16'h1111);
    expect_point(0, 480, 16'h2222); push_point(0, 480, 16'h2222);
    expect_point(639, 479, 16'h3333); push_point(639, 479, 16'h3333);
    wait_flushed("t4 flushed", 40, 1'b0);
    check("t4 drop", 64'(bus.o_drop_count), 64'd2);
    check("t4 pix", 64'(bus.o_pix_count), 64'd1);
    check("t4 corner addr", 64'(got_addr.size() > 0 ? got_addr[0] : 19'd0), 64'd307199);
    drain_check("t4");

    // Reset mid-write with four points buffered abandons everything.
    bus.i_mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_point(10 + i, 20, 16'(i));
    check("t5 we before reset", 64'(bus.o_mem_we), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5 we", 64'(bus.o_mem_we), 64'd0);
    check("t5 flushed", 64'(bus.o_flushed), 64'd1);
    check("t5 pix", 64'(bus.o_pix_count), 64'd0);
    check("t5 drop", 64'(bus.o_drop_count), 64'd0);
    check("t5 overflow", 64'(bus.o_overflow), 64'd0);
    bus.i_mem_ready = 1'b1;
    ticks(10);
    check("t5 no writes", 64'(got_addr.size()), 64'd0);
    bus.i_mem_ready = 1'b0;
    apply_reset();

    // Clear coinciding with an accepted write and with a drop.
    push_point(5, 5, 16'hABCD);
    tick();
    check("t6 we", 64'(bus.o_mem_we), 64'd1);
    bus.i_mem_ready = 1'b1;
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    bus.i_mem_ready = 1'b0;
    check("t6 pix cleared", 64'(bus.o_pix_count), 64'd0);
    push_point(700, 10, 16'h0001);
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    check("t6 drop cleared", 64'(bus.o_drop_count), 64'd0);
    check("t6 flushed", 64'(bus.o_flushed), 64'd1);

    // Randomized bursts of at most six points, so the FIFO can never overflow.
    apply_reset();
    for (int b = 0; b < 25; b++) begin
      bus.i_done = 1'b0;
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        bus.i_mem_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 2) == 0) tick();
        rand_point(x, y);
        c = 16'($urandom);
        expect_point(x, y, c);
        push_point(x, y, c);
      end
      bus.i_done = 1'b1;
      wait_flushed("rand flushed", 300, 1'b1);
      check("rand pix", 64'(bus.o_pix_count), 64'(exp_pix));
      check("rand drop", 64'(bus.o_drop_count), 64'(exp_drops));
      check("rand overflow", 64'(bus.o_overflow), 64'd0);
      drain_check("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
